// File: rtl/hdlc_tx_channel_if.sv
// hdlc_tx_channel_if: Tx buffer handshake and serial-line signals of the HDLC transmitter
// Ports (master = buffer/line side, slave = transmitter):
//   tx_enable, tx_data_avail, tx_data[7:0], tx_abort_frame  -> transmitter
//   tx_new_byte, tx, tx_valid_frame, tx_done, tx_aborted_trans <- transmitter
interface hdlc_tx_channel_if;
    logic       tx_enable;
    logic       tx_data_avail;
    logic [7:0] tx_data;
    logic       tx_abort_frame;
    logic       tx_new_byte;
    logic       tx;
    logic       tx_valid_frame;
    logic       tx_done;
    logic       tx_aborted_trans;
    modport master (
        output tx_enable, tx_data_avail, tx_data, tx_abort_frame,
        input  tx_new_byte, tx, tx_valid_frame, tx_done, tx_aborted_trans
    );
    modport slave (
        input  tx_enable, tx_data_avail, tx_data, tx_abort_frame,
        output tx_new_byte, tx, tx_valid_frame, tx_done, tx_aborted_trans
    );
endinterface

// File: rtl/hdlc_tx_channel.sv
// hdlc_tx_channel: bit-level HDLC transmitter (idle, flags, zero insertion, abort, optional CRC-16 FCS)
// Optional FCS generation is enabled by defining the macro HDLC_TX_FCS_EN.
// Ports: clk_i clock, rst_i synchronous active-high reset,
//   bus (slave): tx_enable/tx_data_avail/tx_data/tx_abort_frame in,
//                tx_new_byte/tx/tx_valid_frame/tx_done/tx_aborted_trans out.
module hdlc_tx_channel #(
    parameter int MIN_IDLE = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    hdlc_tx_channel_if.slave bus
);
`ifdef HDLC_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START_FLAG, DATA, END_FLAG, ABORT} state_t;
`endif
    localparam logic [7:0] FLAG = 8'h7E;
    localparam logic [7:0] IDLE_MAX = 8'(MIN_IDLE);
    // state_q/bit_q describe the bit currently on the line; during a stuffed
    // zero they already point at the payload bit that follows it.
    state_t     state_q, state_d, nstate;
    logic [3:0] bit_q, bit_d, nbit, last_bit;
    logic [2:0] ones_q, ones_d;
    logic [7:0] idle_q, idle_d, byte_q, byte_d;
    logic       stuff_q, stuff_d, tx_q, tx_d, done_q, done_d, aborted_q, aborted_d;
    logic       payload, boundary, pending, consume;
`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc_q, crc_d;
`endif
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        ones_d = ones_q;
        idle_d = idle_q;
        byte_d = byte_q;
        stuff_d = stuff_q;
        tx_d = 1'b1;
        done_d = 1'b0;
        aborted_d = aborted_q;
        nstate = state_q;
        nbit = bit_q;
        consume = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crc_d = crc_q;
        payload = state_q == DATA || state_q == FCS;
        last_bit = state_q == FCS ? 4'd15 : 4'd7;
`else
        payload = state_q == DATA;
        last_bit = 4'd7;
`endif
        boundary = !stuff_q && bit_q == 4'd7 && (state_q == START_FLAG || state_q == DATA);
        pending = payload && !stuff_q && ones_q == 3'd5;
        if (state_q == IDLE) begin
            idle_d = idle_q == IDLE_MAX ? idle_q : idle_q + 8'd1;
            if (idle_q == IDLE_MAX && bus.tx_enable && bus.tx_data_avail) begin
                state_d = START_FLAG;
                bit_d = 4'd0;
                stuff_d = 1'b0;
                ones_d = 3'd0;
                aborted_d = 1'b0;
                tx_d = FLAG[0];
`ifdef HDLC_TX_FCS_EN
                crc_d = 16'hFFFF;
`endif
            end
        end else if (state_q != ABORT && bus.tx_abort_frame) begin
            state_d = ABORT;
            bit_d = 4'd0;
            stuff_d = 1'b0;
            aborted_d = 1'b1;
            tx_d = 1'b0;
        end else begin
            // find the next non-stuffed bit; a stuffed slot already holds it
            if (!stuff_q) begin
                if (boundary) begin
                    consume = bus.tx_data_avail;
                    nbit = 4'd0;
                    byte_d = consume ? bus.tx_data : byte_q;
`ifdef HDLC_TX_FCS_EN
                    nstate = consume ? DATA : FCS;
`else
                    nstate = consume ? DATA : END_FLAG;
`endif
                end else if (bit_q == last_bit) begin
                    nbit = 4'd0;
                    nstate = state_q == END_FLAG || state_q == ABORT ? IDLE : END_FLAG;
                end else begin
                    nbit = bit_q + 4'd1;
                end
            end
            state_d = nstate;
            bit_d = nbit;
            stuff_d = pending;
            if (pending) begin
                tx_d = 1'b0;
                ones_d = 3'd0;
            end else if (nstate == IDLE) begin
                done_d = 1'b1;
                idle_d = 8'd0;
            end else if (nstate == DATA) begin
                tx_d = byte_d[nbit[2:0]];
                ones_d = tx_d ? ones_q + 3'd1 : 3'd0;
`ifdef HDLC_TX_FCS_EN
                crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ tx_d) ? 16'h8408 : 16'h0000);
            end else if (nstate == FCS) begin
                tx_d = ~crc_q[nbit];
                ones_d = tx_d ? ones_q + 3'd1 : 3'd0;
`endif
            end else begin
                tx_d = nstate == ABORT ? nbit != 4'd0 : FLAG[nbit[2:0]];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bit_q <= 4'd0;
            ones_q <= 3'd0;
            idle_q <= 8'd0;
            byte_q <= 8'd0;
            stuff_q <= 1'b0;
            tx_q <= 1'b1;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            crc_q <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            ones_q <= ones_d;
            idle_q <= idle_d;
            byte_q <= byte_d;
            stuff_q <= stuff_d;
            tx_q <= tx_d;
            done_q <= done_d;
            aborted_q <= aborted_d;
`ifdef HDLC_TX_FCS_EN
            crc_q <= crc_d;
`endif
        end
    end
    assign bus.tx = tx_q;
    assign bus.tx_new_byte = consume;
    assign bus.tx_valid_frame = stuff_q || state_q == START_FLAG || payload;
    assign bus.tx_done = done_q;
    assign bus.tx_aborted_trans = aborted_q;
endmodule

// File: tb/tb_hdlc_tx_channel.sv
// tb_hdlc_tx_channel: randomized frames checked cycle by cycle against a frame-level line model
module tb_hdlc_tx_channel;
    localparam int MIN_IDLE = 8;
    typedef struct packed {logic tx; logic valid; logic nb;} slot_t;
    typedef struct packed {logic tx; logic valid; logic nb; logic done; logic ab;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] flag = 8'h7E;
    hdlc_tx_channel_if bus();
    hdlc_tx_channel #(.MIN_IDLE(MIN_IDLE)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    exp_t exp_q[$];
    exp_t cur;
    slot_t fr[$];
    int bstart[$];
    logic [7:0] pay[$];
    logic [15:0] m_fcs;
    logic m_ab;
    int m_idle;
    int total = 0;
    int bad = 0;
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endfunction
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("tx", 32'(bus.tx), 32'(cur.tx));
            check("valid_frame", 32'(bus.tx_valid_frame), 32'(cur.valid));
            check("new_byte", 32'(bus.tx_new_byte), 32'(cur.nb));
            check("done", 32'(bus.tx_done), 32'(cur.done));
            check("aborted_trans", 32'(bus.tx_aborted_trans), 32'(cur.ab));
        end
    end
    // one payload bit on the line, followed by a stuffed zero after five ones
    function automatic void put(input logic b, input logic nb, inout int ones);
        fr.push_back({b, 1'b1, nb});
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
            fr.push_back(3'b010);
            ones = 0;
        end
    endfunction
    // expected line slots of a complete frame for the bytes in pay
    function automatic void build();
        logic [15:0] crc;
        int ones;
        crc = 16'hFFFF;
        ones = 0;
        fr.delete();
        bstart.delete();
        for (int i = 0; i < 8; i++) fr.push_back({flag[i], 1'b1, i == 7});
        foreach (pay[j]) begin
            crc ^= {8'h00, pay[j]};
            for (int i = 0; i < 8; i++) crc = crc[0] ? (crc >> 1) ^ 16'h8408 : crc >> 1;
            bstart.push_back(fr.size());
            for (int i = 0; i < 8; i++) put(pay[j][i], i == 7 && j < pay.size() - 1, ones);
        end
        m_fcs = ~crc;
`ifdef HDLC_TX_FCS_EN
        for (int i = 0; i < 16; i++) put(m_fcs[i], 1'b0, ones);
`endif
        for (int i = 0; i < 8; i++) fr.push_back({flag[i], 2'b00});
    endfunction
    task automatic step(input logic rs, input logic en, input logic av, input logic [7:0] d,
                        input logic ab, input exp_t e);
        rst = rs;
        bus.tx_enable = en;
        bus.tx_data_avail = av;
        bus.tx_data = d;
        bus.tx_abort_frame = ab;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    // idle until accepted (request from idle cycle k on), then the frame; optional abort or reset slot
    task automatic run_frame(input int k, input int ab_slot, input int rst_slot);
        int i, idx;
        logic en, av, acc, ab, nb;
        i = 0;
        idx = 0;
        build();
        do begin
            en = i >= k ? 1'b1 : rb();
            av = i >= k ? 1'b1 : (en ? 1'b0 : rb());
            acc = en && av && m_idle >= MIN_IDLE;
            step(1'b0, en, av, pay[0], rb(), {1'b1, 1'b0, 1'b0, 1'b0, m_ab});
            m_idle++;
            i++;
        end while (!acc);
        m_ab = 1'b0;
        for (int s = 0; s < fr.size(); s++) begin
            ab = s == ab_slot;
            nb = fr[s].nb && !ab;
            step(s == rst_slot, rb(), idx < pay.size(), idx < pay.size() ? pay[idx] : 8'($urandom),
                 ab, {fr[s].tx, fr[s].valid, nb, 1'b0, 1'b0});
            if (s == rst_slot) begin
                m_idle = 0;
                m_ab = 1'b0;
                return;
            end
            if (ab) begin
                for (int a = 0; a < 8; a++) step(1'b0, rb(), rb(), 8'($urandom), rb(), {a != 0, 4'b0001});
                m_ab = 1'b1;
                break;
            end
            if (nb) idx++;
        end
        step(1'b0, rb(), rb(), 8'($urandom), rb(), {1'b1, 1'b0, 1'b0, 1'b1, m_ab});
        m_idle = 1;
    endtask
    initial begin
        logic [23:0] v;
        int a;
        bus.tx_enable = 1'b0;
        bus.tx_data_avail = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_abort_frame = 1'b0;
        m_ab = 1'b0;
        m_idle = 0;
        pay = '{8'h00};
        build();
        v = '0;
        for (int s = 0; s < 16; s++) v[23 - s] = fr[s].tx;
        check("pin_00_head", 32'(v[23:8]), 32'b0111111000000000);
`ifndef HDLC_TX_FCS_EN
        for (int s = 16; s < 24; s++) v[23 - s] = fr[s].tx;
        check("pin_00_frame", 32'(v), 32'b011111100000000001111110);
        check("pin_00_len", fr.size(), 24);
`endif
        pay = '{8'hFF};
        build();
        v = '0;
        for (int s = 8; s < 17; s++) v[16 - s] = fr[s].tx;
        check("pin_ff_payload", 32'(v[8:0]), 32'b111110111);
`ifndef HDLC_TX_FCS_EN
        check("pin_ff_len", fr.size(), 25);
`endif
        pay = '{8'h1F, 8'h01};
        build();
        check("pin_1f_second_start", bstart[1], 17);
        check("pin_1f_newbyte_gap", 32'(fr[16].nb), 32'd1);
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build();
        check("pin_crc_check", 32'(m_fcs), 32'h906E);
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'b10000);
        m_idle = 0;
        pay = '{8'h00};
        run_frame(10, -1, -1);
        pay = '{8'hFF};
        run_frame(0, -1, -1);
        pay = '{8'h1F, 8'h01};
        run_frame(3, -1, -1);
        pay = '{8'hA5, 8'h3C};
        build();
        a = bstart[1] + 2;
        run_frame(2, a, -1);
        pay = '{8'h55, 8'hAA};
        run_frame(0, -1, 12);
        pay = '{8'h7E, 8'hF8, 8'h3F};
        run_frame(0, -1, -1);
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(20, -1, -1);
        repeat (40) begin
            pay.delete();
            repeat ($urandom_range(1, 5)) pay.push_back($urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
            build();
            a = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, fr.size() - 1)) : -1;
            run_frame($urandom_range(0, 14), a, -1);
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
